uart_rx_sampler: RTL and testbench
==================================

Name: uart_rx_sampler

Overview:
- UART receive stage fed by the 16x baud-tick generator. It consumes the one-clk `baud_clock` pulse and oversamples the serial `rx` line.
- Validates start bits, majority-votes each bit at mid-cell, then assembles a 7/8-bit character with optional parity.
- Presents the character in a single holding register with valid/read handshake and error flags to the APB register/FIFO layer.

Parameters:
- SYNC_STAGES, 2, metastability flops on `rx`; legal values are 2..3.
- MID_SAMPLE, 8, centre oversample index; votes use MID_SAMPLE-1, MID_SAMPLE and MID_SAMPLE+1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- baud_clock  in  1  16x oversample enable, one-clk pulse
- rx  in  1  asynchronous serial input, idle high
- bit8  in  1  1 = 8 data bits, 0 = 7 data bits
- parity_en  in  1  1 = parity bit present
- odd_n_even  in  1  1 = odd parity, 0 = even parity
- read_rx_byte  in  1  one-clk pulse that consumes the held character
- rx_data  out  8  received character, LSB = first bit received
- rx_valid  out  1  holding register full
- parity_err  out  1  parity error on the held character
- framing_err  out  1  stop bit sampled low on the held character
- overflow  out  1  character lost while rx_valid = 1 (sticky)
- rx_idle  out  1  FSM in IDLE

Behaviour:
- **Reset** (clk edge with reset = 1): sync chain = 1, FSM = IDLE, samp_cnt = 0. Outputs: rx_data = 0, rx_valid = 0, parity_err = 0, framing_err = 0, overflow = 0, rx_idle = 1. Reset mid-frame abandons the frame with no flags.
- **Advance rule:** all FSM/counter activity advances only on clk edges where baud_clock = 1. samp_cnt is 4-bit and wraps 15 -> 0.
- **Bit decision:** samples at samp_cnt = 7, 8, 9 are captured; bit = majority(2 of 3). The decision is taken on the tick where samp_cnt = 9.
- **IDLE:** on a tick with synced rx = 0, go to START, samp_cnt = 1. Latch bit8/parity_en/odd_n_even; these are held constant until the frame ends, so mid-frame config changes are ignored.
- **START:**
  - Decision = 1 (glitch) -> IDLE, no flags.
  - Decision = 0 -> on the wrap tick, go to DATA with bit_idx = 0.
- **DATA:**
  - Each decision shifts into the shift register, LSB first.
  - On the wrap tick after the last bit (bit_idx = 7, or 6 in 7-bit mode) go to PARITY if parity enabled, else STOP.
- **PARITY:**
  - Decision captured as p.
  - perr = XOR(data bits, p) XOR odd_n_even, i.e. error if the XOR = 1 in even mode or 0 in odd mode.
  - Go to STOP on the wrap tick.
- **STOP:** on the decision tick (samp_cnt = 9), complete the character:
  - stop = 1 -> IDLE immediately, so a start bit half a cell later is still caught.
  - stop = 0 -> WAIT_HIGH; stay there until a tick sees synced rx = 1, then IDLE. A held-low break yields exactly one character.
- **Completion (rx_valid = 0, or read_rx_byte = 1 in the same cycle):**
  - Next clk: rx_data = character (bit7 forced 0 in 7-bit mode).
  - parity_err = perr & parity_en; framing_err = ~stop; rx_valid = 1.
  - Latency: flags and data are visible one clk after the stop decision edge.
- **Completion while rx_valid = 1 and no read:** the new character is discarded, held data/flags are unchanged, and overflow is set.
- **read_rx_byte with rx_valid = 1:** next clk rx_valid = 0, parity_err = 0, framing_err = 0, overflow = 0. read_rx_byte with rx_valid = 0 has no effect.
- **Simultaneous read and completion:** the new character is loaded, rx_valid stays 1, and overflow is not set.
- **Ticks:** ticks with no pending decision only increment samp_cnt. No activity occurs between ticks.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_t (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH)
  - constants OVERSAMPLE = 16, MID_SAMPLE default, and DATA_W = 8.
- One sub-module, uart_rx_bit_voter: SYNC_STAGES synchroniser plus the 3-sample capture and majority output, gated by baud_clock and samp_cnt.

Test Plan (baud_clock pulse every 4 clk, so one bit = 64 clk):
- 8N1, send 0xA5, stop = 1 -> rx_valid rises one clk after the stop decision tick; rx_data = 0xA5; all flags = 0.
- 7-bit, even parity, send 0x41 with parity bit 1 (wrong) -> rx_data = 0x41, parity_err = 1. Repeat with odd parity and parity bit 1 -> parity_err = 0.
- Low glitch of 3 ticks in IDLE -> FSM returns to IDLE, rx_valid stays 0. Then a 1-sample glitch inside a data bit at samp_cnt = 8 -> the bit is still correct via majority.
- Stop bit 0 then line held low 40 bit-times -> exactly one character 0x00 with framing_err = 1; a following 0x3C frame received cleanly after rx returns high.
- Two back-to-back frames 0x11 and 0x22 with no read -> rx_data = 0x11, overflow = 1. Read on the exact completion cycle of frame 2 instead -> rx_data = 0x22, overflow = 0.
- Assert reset during bit 4 of a frame -> all outputs at reset values next clk; the next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned OVERSAMPLE         = 16;
    localparam int unsigned MID_SAMPLE_DEFAULT = 8;
    localparam int unsigned DATA_W             = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Holding-register handshake between the receiver and the register/FIFO layer.
interface uart_rx_sampler_if;
    import uart_pkg::*;

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              parity_err;
    logic              framing_err;
    logic              overflow;
    logic              rx_idle;
    logic              read_rx_byte;

    modport master (
        output rx_data, rx_valid, parity_err, framing_err, overflow, rx_idle,
        input  read_rx_byte
    );

    modport slave (
        input  rx_data, rx_valid, parity_err, framing_err, overflow, rx_idle,
        output read_rx_byte
    );

endinterface

// File: rtl/uart_rx_bit_voter.sv
// Synchronises rx and forms a 2-of-3 majority from the samples around mid-cell.
module uart_rx_bit_voter
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MID_SAMPLE  = MID_SAMPLE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          baud_clock,
    input  logic                          rx,
    input  logic [$clog2(OVERSAMPLE)-1:0] samp_cnt,
    output logic                          rx_sync,
    output logic                          decision
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] EARLY_CNT = CW'(MID_SAMPLE - 1);
    localparam logic [CW-1:0] MID_CNT   = CW'(MID_SAMPLE);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s_early;
    logic                   s_mid;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync    <= '1;
            s_early <= 1'b1;
            s_mid   <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
            if (baud_clock && samp_cnt == EARLY_CNT) s_early <= sync[SYNC_STAGES-1];
            if (baud_clock && samp_cnt == MID_CNT)   s_mid   <= sync[SYNC_STAGES-1];
        end
    end

    assign rx_sync = sync[SYNC_STAGES-1];
    // Third vote is the live sample, so the result is only meaningful on the MID+1 tick.
    assign decision = (s_early & s_mid) | (s_early & rx_sync) | (s_mid & rx_sync);

endmodule

// File: rtl/uart_rx_sampler.sv
// UART receive FSM: start validation, bit assembly, parity/stop checks, holding register.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MID_SAMPLE  = MID_SAMPLE_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    input logic                baud_clock,
    input logic                rx,
    input logic                bit8,
    input logic                parity_en,
    input logic                odd_n_even,
    uart_rx_sampler_if.master  host
);
    localparam int unsigned CW = $clog2(OVERSAMPLE);
    localparam int unsigned IW = $clog2(DATA_W);
    localparam logic [CW-1:0] DEC_CNT  = CW'(MID_SAMPLE + 1);
    localparam logic [CW-1:0] WRAP_CNT = CW'(OVERSAMPLE - 1);

    rx_state_t         state, state_n;
    logic [CW-1:0]     samp_cnt, samp_cnt_n;
    logic [IW-1:0]     bit_idx, bit_idx_n;
    logic              rx_sync, decision;
    logic              dec_tick, wrap_tick, start_frame, complete;
    logic              cfg_bit8, cfg_par, cfg_odd;
    logic [DATA_W-1:0] shreg;
    logic              par_bit, stop_bit, done;
    logic [DATA_W-1:0] char_data;
    logic              char_perr;
    logic [DATA_W-1:0] data_q;
    logic              valid_q, perr_q, ferr_q, ovf_q;

    uart_rx_bit_voter #(
        .SYNC_STAGES (SYNC_STAGES),
        .MID_SAMPLE  (MID_SAMPLE)
    ) u_voter (
        .clk        (clk),
        .reset      (reset),
        .baud_clock (baud_clock),
        .rx         (rx),
        .samp_cnt   (samp_cnt),
        .rx_sync    (rx_sync),
        .decision   (decision)
    );

    assign dec_tick  = baud_clock && (samp_cnt == DEC_CNT);
    assign wrap_tick = baud_clock && (samp_cnt == WRAP_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            samp_cnt <= '0;
            bit_idx  <= '0;
        end else begin
            state    <= state_n;
            samp_cnt <= samp_cnt_n;
            bit_idx  <= bit_idx_n;
        end
    end

    always_comb begin
        state_n     = state;
        samp_cnt_n  = samp_cnt;
        bit_idx_n   = bit_idx;
        start_frame = 1'b0;
        complete    = 1'b0;
        if (baud_clock) begin
            samp_cnt_n = samp_cnt + CW'(1);
            case (state)
                IDLE: begin
                    samp_cnt_n = '0;
                    if (!rx_sync) begin
                        state_n     = START;
                        samp_cnt_n  = CW'(1);
                        start_frame = 1'b1;
                    end
                end
                START: begin
                    if (dec_tick && decision) begin
                        state_n    = IDLE;
                        samp_cnt_n = '0;
                    end else if (wrap_tick) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end
                end
                DATA: begin
                    if (wrap_tick) begin
                        if (bit_idx == (cfg_bit8 ? IW'(7) : IW'(6)))
                            state_n = cfg_par ? PARITY : STOP;
                        else
                            bit_idx_n = bit_idx + IW'(1);
                    end
                end
                PARITY: if (wrap_tick) state_n = STOP;
                STOP: begin
                    if (dec_tick) begin
                        complete   = 1'b1;
                        samp_cnt_n = '0;
                        state_n    = decision ? IDLE : WAIT_HIGH;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_sync) begin
                        state_n    = IDLE;
                        samp_cnt_n = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_bit8 <= 1'b1;
            cfg_par  <= 1'b0;
            cfg_odd  <= 1'b0;
            shreg    <= '0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= complete;
            if (start_frame) begin
                cfg_bit8 <= bit8;
                cfg_par  <= parity_en;
                cfg_odd  <= odd_n_even;
                shreg    <= '0;
                par_bit  <= 1'b0;
            end
            if (dec_tick && state == DATA)   shreg[bit_idx] <= decision;
            if (dec_tick && state == PARITY) par_bit <= decision;
            if (complete)                    stop_bit <= decision;
        end
    end

    // Unused bit 7 stays cleared in 7-bit mode, so XOR over the whole register is safe.
    assign char_data = {cfg_bit8 & shreg[DATA_W-1], shreg[DATA_W-2:0]};
    assign char_perr = (^shreg ^ par_bit ^ cfg_odd) & cfg_par;

    // Completion is registered in done, so the holding register updates one clk after the stop decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (host.read_rx_byte && valid_q) begin
                valid_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
            if (done) begin
                if (!valid_q || host.read_rx_byte) begin
                    data_q  <= char_data;
                    perr_q  <= char_perr;
                    ferr_q  <= ~stop_bit;
                    valid_q <= 1'b1;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
        end
    end

    assign host.rx_data     = data_q;
    assign host.rx_valid    = valid_q;
    assign host.parity_err  = perr_q;
    assign host.framing_err = ferr_q;
    assign host.overflow    = ovf_q;
    assign host.rx_idle     = (state == IDLE);

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed, table-driven bench for uart_rx_sampler with a 4-clk baud tick.
module tb_uart_rx_sampler;

    logic clk;
    logic reset;
    logic baud_clock;
    logic rx;
    logic bit8;
    logic parity_en;
    logic odd_n_even;

    uart_rx_sampler_if bus ();

    uart_rx_sampler #(
        .SYNC_STAGES (2),
        .MID_SAMPLE  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .baud_clock (baud_clock),
        .rx         (rx),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .host       (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        logic [7:0]  data;
        int unsigned nbits;
        logic        par_en;
        logic        odd;
        logic        pbit;
        logic        stopb;
        int          gl_bit;
        logic [7:0]  exp_data;
        logic        exp_perr;
        logic        exp_ferr;
    } vec_t;

    vec_t vecs [8];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        baud_clock = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            baud_clock = 1'b1;
            @(negedge clk);
            baud_clock = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time=%0t limit=2000000", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%02h expected=0x%02h", name, act, exp);
        end
    endtask

    task automatic align_tick();
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            if (baud_clock) break;
        end
    endtask

    task automatic do_read();
        @(negedge clk);
        bus.read_rx_byte = 1'b1;
        @(negedge clk);
        bus.read_rx_byte = 1'b0;
    endtask

    // Each cell is 64 clk; stop decision lands 40 clk into the stop cell.
    task automatic send_frame(input logic [7:0] d, input int unsigned nbits, input logic par_en,
                              input logic pbit, input logic stopb, input logic rd_at_done,
                              input int gl_bit, output logic pre, output logic post);
        align_tick();
        @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < int'(nbits); i++) begin
            rx = d[i];
            if (i == gl_bit) begin
                repeat (33) @(negedge clk);
                rx = ~d[i];
                @(negedge clk);
                rx = d[i];
                repeat (30) @(negedge clk);
            end else begin
                repeat (64) @(negedge clk);
            end
        end
        if (par_en) begin
            rx = pbit;
            repeat (64) @(negedge clk);
        end
        rx = stopb;
        repeat (40) @(posedge clk);
        #1 pre = bus.rx_valid;
        if (rd_at_done) bus.read_rx_byte = 1'b1;
        @(posedge clk);
        #1 post = bus.rx_valid;
        bus.read_rx_byte = 1'b0;
        repeat (24) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data"},  bus.rx_data, 8'h00);
        chk({tag, "_valid"}, {7'b0, bus.rx_valid}, 8'd0);
        chk({tag, "_perr"},  {7'b0, bus.parity_err}, 8'd0);
        chk({tag, "_ferr"},  {7'b0, bus.framing_err}, 8'd0);
        chk({tag, "_ovf"},   {7'b0, bus.overflow}, 8'd0);
        chk({tag, "_idle"},  {7'b0, bus.rx_idle}, 8'd1);
    endtask

    initial begin
        logic pre, post;
        logic [7:0] d5a;

        vecs[0] = '{8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, -1, 8'h41, 1'b1, 1'b0};
        vecs[2] = '{8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, -1, 8'h41, 1'b0, 1'b0};
        vecs[3] = '{8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, -1, 8'h3C, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 7, 1'b0, 1'b0, 1'b0, 1'b1, -1, 8'h7F, 1'b0, 1'b0};
        vecs[5] = '{8'h80, 8, 1'b1, 1'b1, 1'b0, 1'b0, -1, 8'h80, 1'b0, 1'b1};
        vecs[6] = '{8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1,  3, 8'h96, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 8, 1'b1, 1'b1, 1'b1, 1'b1, -1, 8'h07, 1'b1, 1'b0};

        rx = 1'b1;
        reset = 1'b1;
        bit8 = 1'b1;
        parity_en = 1'b0;
        odd_n_even = 1'b0;
        bus.read_rx_byte = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;
        repeat (64) @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            bit8       = (vecs[i].nbits == 8);
            parity_en  = vecs[i].par_en;
            odd_n_even = vecs[i].odd;
            send_frame(vecs[i].data, vecs[i].nbits, vecs[i].par_en, vecs[i].pbit,
                       vecs[i].stopb, 1'b0, vecs[i].gl_bit, pre, post);
            rx = 1'b1;
            chk($sformatf("v%0d_pre", i),  {7'b0, pre}, 8'd0);
            chk($sformatf("v%0d_post", i), {7'b0, post}, 8'd1);
            chk($sformatf("v%0d_data", i), bus.rx_data, vecs[i].exp_data);
            chk($sformatf("v%0d_perr", i), {7'b0, bus.parity_err}, {7'b0, vecs[i].exp_perr});
            chk($sformatf("v%0d_ferr", i), {7'b0, bus.framing_err}, {7'b0, vecs[i].exp_ferr});
            chk($sformatf("v%0d_ovf", i),  {7'b0, bus.overflow}, 8'd0);
            do_read();
            chk($sformatf("v%0d_rd_valid", i), {7'b0, bus.rx_valid}, 8'd0);
            chk($sformatf("v%0d_rd_flags", i), {6'b0, bus.parity_err, bus.framing_err}, 8'd0);
            repeat (64) @(negedge clk);
        end

        // Short low glitch in IDLE must not produce a character.
        bit8 = 1'b1;
        parity_en = 1'b0;
        align_tick();
        @(negedge clk);
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        chk("glitch_in_start", {7'b0, bus.rx_idle}, 8'd0);
        repeat (44) @(negedge clk);
        chk("glitch_idle", {7'b0, bus.rx_idle}, 8'd1);
        chk("glitch_valid", {7'b0, bus.rx_valid}, 8'd0);
        repeat (64) @(negedge clk);

        // Break: stop low, line held low for 40 bit times.
        send_frame(8'h00, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, pre, post);
        repeat (40 * 64) @(negedge clk);
        chk("break_wait_high", {7'b0, bus.rx_idle}, 8'd0);
        chk("break_valid", {7'b0, bus.rx_valid}, 8'd1);
        chk("break_data", bus.rx_data, 8'h00);
        chk("break_ferr", {7'b0, bus.framing_err}, 8'd1);
        chk("break_ovf", {7'b0, bus.overflow}, 8'd0);
        rx = 1'b1;
        repeat (64) @(negedge clk);
        chk("break_idle", {7'b0, bus.rx_idle}, 8'd1);
        do_read();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, pre, post);
        chk("after_break_data", bus.rx_data, 8'h3C);
        chk("after_break_ferr", {7'b0, bus.framing_err}, 8'd0);
        chk("after_break_valid", {7'b0, post}, 8'd1);
        do_read();

        // Overflow: second frame lost while the first is unread.
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, pre, post);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, pre, post);
        chk("ovf_pre", {7'b0, pre}, 8'd1);
        chk("ovf_data", bus.rx_data, 8'h11);
        chk("ovf_flag", {7'b0, bus.overflow}, 8'd1);

        // Reset during data bit 4 clears everything; next frame is clean.
        d5a = 8'h5A;
        align_tick();
        @(negedge clk);
        rx = 1'b0;
        repeat (64) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = d5a[i];
            repeat (64) @(negedge clk);
        end
        rx = d5a[4];
        repeat (32) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 chk_reset_vals("midreset");
        @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        repeat (128) @(negedge clk);
        chk("midreset_quiet", {7'b0, bus.rx_valid}, 8'd0);
        send_frame(d5a, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, pre, post);
        chk("post_reset_data", bus.rx_data, 8'h5A);
        chk("post_reset_post", {7'b0, post}, 8'd1);
        chk("post_reset_flags", {5'b0, bus.parity_err, bus.framing_err, bus.overflow}, 8'd0);
        do_read();

        // Read on the exact completion cycle of the second frame.
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1'b0, -1, pre, post);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1'b1, -1, pre, post);
        chk("rdc_post", {7'b0, post}, 8'd1);
        chk("rdc_data", bus.rx_data, 8'h22);
        chk("rdc_ovf", {7'b0, bus.overflow}, 8'd0);
        do_read();
        chk("rdc_final_valid", {7'b0, bus.rx_valid}, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
